// File: rtl/io_read_port_buffer_pkg.sv
// Common types and sizing helpers for the read-port buffer slice.
package io_read_port_buffer_pkg;

    // Per-cycle activity of one slot, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } slot_op_t;

    // Pointer width for a power-of-two depth; pointers wrap naturally.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/io_ef_defs.sv
// Shared Empty/Full encoding used by the read-side I/O check blocks.
// Any block that reports per-port occupancy includes this file.
`ifndef IO_EF_DEFS_SV
`define IO_EF_DEFS_SV

`define EMPTY 1'b0
`define FULL  1'b1

`endif

// File: rtl/io_read_port_slot.sv
// One read port: a small FIFO with an occupancy counter and a sticky
// underflow flag. The head word is read straight out of the array so it
// is visible the cycle after it was written.
`ifndef IO_EF_DEFS_SV
`include "io_ef_defs.sv"
`endif

module io_read_port_slot
    import io_read_port_buffer_pkg::*;
#(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rden,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  port_ef,
    output logic                  underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  underflow_reg, underflow_next;
    logic                  push;
    logic                  pop;
    slot_op_t              op;

    // Handshake and status depend only on registered occupancy.
    assign in_ready  = (count_reg != CNT_W'(DEPTH));
    assign port_ef   = (count_reg != '0) ? `FULL : `EMPTY;
    assign read_data = mem[rd_ptr_reg];
    assign underflow = underflow_reg;

    // A pop on an empty slot is dropped, even when a push lands that cycle.
    assign push = in_valid && in_ready;
    assign pop  = rden && (count_reg != '0);
    assign op   = slot_op_t'({push, pop});

    // Next-state for pointers, occupancy and the sticky underflow bit.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        underflow_next = underflow_reg | (rden && (count_reg == '0));
        case (op)
            OP_PUSH: begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                count_next  = count_reg + CNT_W'(1);
            end
            OP_POP: begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
                count_next  = count_reg - CNT_W'(1);
            end
            OP_BOTH: begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            default: ;
        endcase
    end

    // Control state register; reset empties the slot at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            underflow_reg <= underflow_next;
        end
    end

    // Word storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: rtl/io_read_port_buffer.sv
// Bank of independent read-port buffers; this level only slices the
// flat producer/consumer buses into per-port slots.
module io_read_port_buffer
    import io_read_port_buffer_pkg::*;
#(
    parameter int WORD_WIDTH = 36,
    parameter int PORT_COUNT = 4,
    parameter int DEPTH      = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [PORT_COUNT*WORD_WIDTH-1:0] in_data,
    input  logic [PORT_COUNT-1:0]            in_valid,
    output logic [PORT_COUNT-1:0]            in_ready,
    input  logic [PORT_COUNT-1:0]            rden,
    output logic [PORT_COUNT*WORD_WIDTH-1:0] read_data,
    output logic [PORT_COUNT-1:0]            port_EF,
    output logic [PORT_COUNT-1:0]            underflow
);

    genvar gi;
    generate
        for (gi = 0; gi < PORT_COUNT; gi++) begin : g_slot
            io_read_port_slot #(
                .WORD_WIDTH (WORD_WIDTH),
                .DEPTH      (DEPTH)
            ) u_slot (
                .clock     (clock),
                .reset_n   (reset_n),
                .in_data   (in_data[gi*WORD_WIDTH +: WORD_WIDTH]),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .rden      (rden[gi]),
                .read_data (read_data[gi*WORD_WIDTH +: WORD_WIDTH]),
                .port_ef   (port_EF[gi]),
                .underflow (underflow[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_io_read_port_buffer.sv
// Bench for io_read_port_buffer: directed scenarios followed by random
// traffic, all checked against a queue-per-port reference model.
module tb_io_read_port_buffer;

    localparam int WW = 36;
    localparam int PC = 4;
    localparam int DP = 2;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [PC*WW-1:0]   in_data;
    logic [PC-1:0]      in_valid;
    logic [PC-1:0]      in_ready;
    logic [PC-1:0]      rden;
    logic [PC*WW-1:0]   read_data;
    logic [PC-1:0]      port_EF;
    logic [PC-1:0]      underflow;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue of words per port plus sticky underflow bits.
    logic [WW-1:0] mq [PC][$];
    logic [PC-1:0] muf;
    bit            verbose;

    always #5 clock = ~clock;

    io_read_port_buffer #(
        .WORD_WIDTH (WW),
        .PORT_COUNT (PC),
        .DEPTH      (DP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rden      (rden),
        .read_data (read_data),
        .port_EF   (port_EF),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < PC; p++) mq[p].delete();
        muf = '0;
    endtask

    task automatic check_all();
        for (int p = 0; p < PC; p++) begin
            check($sformatf("ef%0d", p), 64'(port_EF[p]), 64'(mq[p].size() != 0));
            check($sformatf("rdy%0d", p), 64'(in_ready[p]), 64'(mq[p].size() < DP));
            check($sformatf("uf%0d", p), 64'(underflow[p]), 64'(muf[p]));
            if (mq[p].size() != 0)
                check($sformatf("data%0d", p), 64'(read_data[p*WW +: WW]), 64'(mq[p][0]));
        end
    endtask

    // One clock: decide from the model what the edge does, apply it after
    // the edge, then compare every port.
    task automatic cycle(input string what);
        bit            pu [PC];
        bit            po [PC];
        logic [WW-1:0] wd [PC];
        for (int p = 0; p < PC; p++) begin
            pu[p] = in_valid[p] && (mq[p].size() < DP);
            po[p] = rden[p] && (mq[p].size() != 0);
            wd[p] = in_data[p*WW +: WW];
            if (rden[p] && mq[p].size() == 0) muf[p] = 1'b1;
        end
        @(posedge clock);
        #1;
        for (int p = 0; p < PC; p++) begin
            if (po[p]) void'(mq[p].pop_front());
            if (pu[p]) mq[p].push_back(wd[p]);
        end
        check_all();
        if (verbose)
            $display("txn %s: valid=%b rden=%b ready=%b ef=%b uf=%b",
                     what, in_valid, rden, in_ready, port_EF, underflow);
    endtask

    initial begin
        logic [63:0] r;
        int          sel;

        verbose  = 1'b1;
        reset_n  = 1'b0;
        in_data  = '0;
        in_valid = '0;
        rden     = '0;
        model_clear();

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_ef", 64'(port_EF), 64'(4'b0000));
        check("rst_rdy", 64'(in_ready), 64'(4'b1111));
        check("rst_uf", 64'(underflow), 64'(4'b0000));
        $display("txn reset: ef=%b ready=%b uf=%b", port_EF, in_ready, underflow);
        reset_n = 1'b1;

        // Fill port 0 past its depth; the third word must stall.
        in_valid = 4'b0001;
        in_data[0 +: WW] = 36'h1;
        cycle("push 0x1");
        in_data[0 +: WW] = 36'h2;
        cycle("push 0x2");
        in_data[0 +: WW] = 36'h3;
        cycle("push 0x3 stalled");
        check("stall_rdy", 64'(in_ready[0]), 64'(0));
        check("stall_head", 64'(read_data[0 +: WW]), 64'h1);
        in_valid = '0;
        rden = 4'b0001;
        cycle("pop");
        check("after_pop_head", 64'(read_data[0 +: WW]), 64'h2);
        cycle("pop");
        rden = '0;
        check("drained_ef", 64'(port_EF[0]), 64'(0));

        // Push and pop together at occupancy 1.
        in_valid = 4'b0001;
        in_data[0 +: WW] = 36'h5;
        cycle("push 0x5");
        in_data[0 +: WW] = 36'hA;
        rden = 4'b0001;
        cycle("push 0xA + pop");
        check("pp_ef", 64'(port_EF[0]), 64'(1));
        check("pp_rdy", 64'(in_ready[0]), 64'(1));
        check("pp_head", 64'(read_data[0 +: WW]), 64'hA);
        in_valid = '0;
        cycle("pop");
        rden = '0;

        // Read from empty port 2.
        rden = 4'b0100;
        cycle("rden empty p2");
        rden = '0;
        check("uf_bits", 64'(underflow), 64'(4'b0100));
        check("uf_ef", 64'(port_EF), 64'(4'b0000));
        check("uf_rdy", 64'(in_ready), 64'(4'b1111));
        cycle("idle");
        check("uf_sticky", 64'(underflow), 64'(4'b0100));

        // Fill port 1, then reset mid-transfer.
        in_valid = 4'b0010;
        in_data[WW +: WW] = 36'h123456789;
        cycle("push p1");
        in_data[WW +: WW] = 36'hABCDEF012;
        cycle("push p1");
        in_valid = '0;
        check("p1_full_rdy", 64'(in_ready[1]), 64'(0));
        reset_n = 1'b0;
        #1;
        model_clear();
        check("mid_rst_ef", 64'(port_EF), 64'(4'b0000));
        check("mid_rst_rdy", 64'(in_ready), 64'(4'b1111));
        check("mid_rst_uf", 64'(underflow), 64'(4'b0000));
        $display("txn async reset: ef=%b ready=%b uf=%b", port_EF, in_ready, underflow);
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 4'b0010;
        in_data[WW +: WW] = 36'h7;
        cycle("push 0x7 after reset");
        in_valid = '0;
        check("post_rst_data", 64'(read_data[WW +: WW]), 64'h7);

        // Random traffic on all ports; rden stays at most one-hot.
        verbose = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            in_valid = PC'($urandom());
            for (int p = 0; p < PC; p++) begin
                r = {$urandom(), $urandom()};
                in_data[p*WW +: WW] = r[WW-1:0];
            end
            sel  = int'($urandom_range(0, 2 * PC - 1));
            rden = (sel < PC) ? PC'(1 << sel) : '0;
            cycle("random");
            if ((n % 1000) == 999)
                $display("txn random block %0d: ef=%b uf=%b total=%0d bad=%0d",
                         n / 1000, port_EF, underflow, total, bad);
        end
        in_valid = '0;
        rden     = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
